// File: rtl/wb_shared_slave_arbiter.sv
// wb_shared_slave_arbiter
// Registered N-master Wishbone arbiter in front of a single shared slave.
// Round-robin or fixed-priority selection, grant held for the whole bus cycle
// (while the granted master keeps m_cyc high), one idle clock between grants.
// Optional feature macro: ARB_TIMEOUT_EN -- aborts a transfer whose slave has
// not answered within TIMEOUT_CYCLES strobed clocks, returning m_err to the master.
module wb_shared_slave_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_MASTERS*AW-1:0]  m_addr,
    input  logic [NUM_MASTERS*DW-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]     m_we,
    input  logic [NUM_MASTERS-1:0]     m_cyc,
    input  logic [NUM_MASTERS-1:0]     m_stb,
    output logic [DW-1:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]     m_ack,
    output logic [NUM_MASTERS-1:0]     m_err,
    output logic [AW-1:0]              s_addr,
    output logic [DW-1:0]              s_dat_o,
    output logic [DW/8-1:0]            s_sel,
    output logic                       s_we,
    output logic                       s_cyc,
    output logic                       s_stb,
    input  logic [DW-1:0]              s_dat_i,
    input  logic                       s_ack,
    input  logic                       s_err,
    output logic                       grant_vld,
    output logic [IW-1:0]              grant_idx
);

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   grant_idx_reg, grant_idx_next;
    logic [IW-1:0]   last_winner_reg, last_winner_next;
    logic [IW-1:0]   winner;
    logic [NUM_MASTERS-1:0] req;
    logic            abort;

    logic [AW-1:0]   addr_arr [NUM_MASTERS];
    logic [DW-1:0]   wdat_arr [NUM_MASTERS];
    logic [DW/8-1:0] sel_arr  [NUM_MASTERS];

    // Slice the flat master buses into per-master views.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign req[gi]      = m_cyc[gi] & m_stb[gi];
        assign addr_arr[gi] = m_addr[gi*AW +: AW];
        assign wdat_arr[gi] = m_dat_i[gi*DW +: DW];
        assign sel_arr[gi]  = m_sel[gi*(DW/8) +: (DW/8)];
    end

    assign grant_vld = (state_reg == ST_GRANT);
    assign grant_idx = grant_idx_reg;
    assign m_dat_o   = s_dat_i;

    // Winner search: scan N entries starting after the last winner (RR) or at 0 (fixed).
    always_comb begin
        logic [IW-1:0] base;
        logic [IW:0]   cand;
        logic          found;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (RR_MODE != 0)
            base = (last_winner_reg == IW'(NUM_MASTERS - 1)) ? '0 : last_winner_reg + 1'b1;
        else
            base = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, base} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_MASTERS))
                cand = cand - (IW+1)'(NUM_MASTERS);
            if (!found && req[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_reg;
    logic          stall;

    assign stall = grant_vld & m_cyc[grant_idx_reg] & m_stb[grant_idx_reg] & ~s_ack & ~s_err;
    assign abort = stall & (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts unanswered strobe clocks, cleared by any completion or by idling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt_reg <= '0;
        else if (!grant_vld || s_ack || s_err || abort)
            tmo_cnt_reg <= '0;
        else if (stall)
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
`else
    // No watchdog: a silent slave holds the grant forever. TIMEOUT_CYCLES is kept
    // in the expression only so the parameter is referenced in this build too.
    assign abort = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Slave-side mux and master-side response routing from the current grant.
    always_comb begin
        s_addr  = addr_arr[grant_idx_reg];
        s_dat_o = wdat_arr[grant_idx_reg];
        s_sel   = sel_arr[grant_idx_reg];
        s_we    = grant_vld & m_we[grant_idx_reg];
        s_cyc   = grant_vld & m_cyc[grant_idx_reg] & ~abort;
        s_stb   = grant_vld & m_cyc[grant_idx_reg] & m_stb[grant_idx_reg] & ~abort;
        m_ack   = '0;
        m_err   = '0;
        if (grant_vld) begin
            m_ack[grant_idx_reg] = s_ack;
            m_err[grant_idx_reg] = s_err | abort;
        end
    end

    // Next-state: arbitrate only from IDLE; release when the owner drops m_cyc or on abort.
    always_comb begin
        state_next       = state_reg;
        grant_idx_next   = grant_idx_reg;
        last_winner_next = last_winner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next       = ST_GRANT;
                    grant_idx_next   = winner;
                    last_winner_next = winner;
                end
            end
            ST_GRANT: begin
                if (!m_cyc[grant_idx_reg] || abort)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            grant_idx_reg   <= '0;
            last_winner_reg <= IW'(NUM_MASTERS - 1);
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            last_winner_reg <= last_winner_next;
        end
    end

endmodule

// File: tb/tb_wb_shared_slave_arbiter.sv
// tb_wb_shared_slave_arbiter
// Directed bench: one round-robin and one fixed-priority 3-master instance share
// the master-side stimulus; each has its own slave acknowledge.
module tb_wb_shared_slave_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*DW/8-1:0] m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [DW-1:0]     s_dat_i;
    logic              s_err, s_ack_man, slv_auto;

    logic [DW-1:0]   rr_m_dat_o, fp_m_dat_o;
    logic [N-1:0]    rr_m_ack, rr_m_err, fp_m_ack, fp_m_err;
    logic [AW-1:0]   rr_s_addr, fp_s_addr;
    logic [DW-1:0]   rr_s_dat_o, fp_s_dat_o;
    logic [DW/8-1:0] rr_s_sel, fp_s_sel;
    logic            rr_s_we, rr_s_cyc, rr_s_stb, rr_s_ack, rr_grant_vld;
    logic            fp_s_we, fp_s_cyc, fp_s_stb, fp_s_ack, fp_grant_vld;
    logic [1:0]      rr_grant_idx, fp_grant_idx;

    // Zero-wait slave when slv_auto is set, otherwise the bench drives the ack by hand.
    assign rr_s_ack = slv_auto ? rr_s_stb : s_ack_man;
    assign fp_s_ack = slv_auto ? fp_s_stb : s_ack_man;

    wb_shared_slave_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT_CYCLES(TMO)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_dat_i(m_dat_i), .m_sel(m_sel), .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
        .m_dat_o(rr_m_dat_o), .m_ack(rr_m_ack), .m_err(rr_m_err),
        .s_addr(rr_s_addr), .s_dat_o(rr_s_dat_o), .s_sel(rr_s_sel), .s_we(rr_s_we),
        .s_cyc(rr_s_cyc), .s_stb(rr_s_stb), .s_dat_i(s_dat_i), .s_ack(rr_s_ack), .s_err(s_err),
        .grant_vld(rr_grant_vld), .grant_idx(rr_grant_idx)
    );

    wb_shared_slave_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT_CYCLES(TMO)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_dat_i(m_dat_i), .m_sel(m_sel), .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
        .m_dat_o(fp_m_dat_o), .m_ack(fp_m_ack), .m_err(fp_m_err),
        .s_addr(fp_s_addr), .s_dat_o(fp_s_dat_o), .s_sel(fp_s_sel), .s_we(fp_s_we),
        .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_dat_i(s_dat_i), .s_ack(fp_s_ack), .s_err(s_err),
        .grant_vld(fp_grant_vld), .grant_idx(fp_grant_idx)
    );

    // Which instance the continuous-request master model follows.
    logic       focus_fp;
    logic       f_vld;
    logic [1:0] f_idx;
    logic [2:0] f_ack;
    assign f_vld = focus_fp ? fp_grant_vld : rr_grant_vld;
    assign f_idx = focus_fp ? fp_grant_idx : rr_grant_idx;
    assign f_ack = focus_fp ? fp_m_ack     : rr_m_ack;

    int         n_checks;
    int         n_errors;
    int         gseq[$];
    logic       prev_vld;
    logic [2:0] drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    // Masters in 'active' keep requesting; a master that sees its ack drops m_cyc for one clock.
    task automatic run_masters(input logic [2:0] active, input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                m_cyc[k] = active[k] & ~drop[k];
                m_stb[k] = active[k] & ~drop[k];
            end
            drop = '0;
            #1;
            if (f_vld && !prev_vld) gseq.push_back(int'(f_idx));
            prev_vld = f_vld;
            if (f_vld && f_ack[f_idx]) drop[f_idx] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        drop  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   err_seen;
        int   first_err;
        int   n_err;
        logic abort_stb;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = 3'b010;
        s_dat_i   = '0;
        s_err     = 1'b0;
        s_ack_man = 1'b1;
        slv_auto  = 1'b0;
        focus_fp  = 1'b0;
        drop      = '0;
        prev_vld  = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]  = 32'(32'h1000 * (k + 1));
            m_dat_i[k*DW +: DW] = 32'(32'hA0 + k);
            m_sel[k*4 +: 4]     = 4'(4'b0001 << k);
        end

        // Reset state, with a stray slave ack present.
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_grant_vld", 32'(rr_grant_vld), 32'd0);
        check_eq("rst_grant_idx", 32'(rr_grant_idx), 32'd0);
        check_eq("rst_s_cyc",     32'(rr_s_cyc),     32'd0);
        check_eq("rst_s_stb",     32'(rr_s_stb),     32'd0);
        check_eq("rst_m_ack",     32'(rr_m_ack),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("stray_ack_drop", 32'(rr_m_ack), 32'd0);
        s_ack_man = 1'b0;

        // Single read by m0, slave answers one clock after the strobe.
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        #1;
        check_eq("t1_req_no_stb", 32'(rr_s_stb), 32'd0);
        check_eq("t1_req_no_vld", 32'(rr_grant_vld), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t1_vld",    32'(rr_grant_vld), 32'd1);
        check_eq("t1_idx",    32'(rr_grant_idx), 32'd0);
        check_eq("t1_s_stb",  32'(rr_s_stb),     32'd1);
        check_eq("t1_s_addr", rr_s_addr,         32'h1000);
        check_eq("t1_s_we",   32'(rr_s_we),      32'd0);
        check_eq("t1_no_ack", 32'(rr_m_ack),     32'd0);
        @(negedge clk);
        s_ack_man = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        check_eq("t1_m_ack",   32'(rr_m_ack), 32'b001);
        check_eq("t1_m_dat_o", rr_m_dat_o,    32'hDEADBEEF);
        @(negedge clk);
        s_ack_man = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        check_eq("t1_rel_s_cyc", 32'(rr_s_cyc),     32'd0);
        check_eq("t1_rel_held",  32'(rr_grant_vld), 32'd1);
        @(negedge clk);
        #1;
        check_eq("t1_idle", 32'(rr_grant_vld), 32'd0);

        // Round robin, all three masters re-requesting against a zero-wait slave.
        do_reset();
        focus_fp = 1'b0; slv_auto = 1'b1; prev_vld = 1'b0;
        gseq.delete();
        run_masters(3'b111, 20);
        check_eq("rr_n_grants", 32'(gseq.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < gseq.size(); i++)
            check_eq($sformatf("rr_grant%0d", i), 32'(gseq[i]), 32'(i % 3));
        for (int i = 1; i < gseq.size(); i++)
            check_eq($sformatf("rr_no_repeat%0d", i), 32'(gseq[i] != gseq[i-1]), 32'd1);
        run_masters(3'b000, 4);

        // Fixed priority: m0 and m2 compete, m0 always wins until it stops.
        focus_fp = 1'b1;
        gseq.delete();
        run_masters(3'b101, 12);
        check_eq("fp_n_grants", 32'(gseq.size() >= 3), 32'd1);
        for (int i = 0; i < gseq.size(); i++)
            check_eq($sformatf("fp_grant%0d", i), 32'(gseq[i]), 32'd0);
        gseq.delete();
        run_masters(3'b100, 8);
        check_eq("fp_m2_granted", 32'(gseq.size() >= 1), 32'd1);
        if (gseq.size() > 0) check_eq("fp_m2_idx", 32'(gseq[0]), 32'd2);
        run_masters(3'b000, 4);
        slv_auto = 1'b0; focus_fp = 1'b0;

        // m1 abandons its cycle before the ack; the late ack must reach nobody.
        @(negedge clk);
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t4_vld",     32'(rr_grant_vld), 32'd1);
        check_eq("t4_idx",     32'(rr_grant_idx), 32'd1);
        check_eq("t4_s_addr",  rr_s_addr,         32'h2000);
        check_eq("t4_s_dat_o", rr_s_dat_o,        32'hA1);
        check_eq("t4_s_sel",   32'(rr_s_sel),     32'b0010);
        check_eq("t4_s_we",    32'(rr_s_we),      32'd1);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        #1;
        check_eq("t4_drop_s_cyc", 32'(rr_s_cyc), 32'd0);
        @(negedge clk);
        s_ack_man = 1'b1;
        #1;
        check_eq("t4_gap_vld",  32'(rr_grant_vld), 32'd0);
        check_eq("t4_late_ack", 32'(rr_m_ack),     32'd0);
        @(negedge clk);
        s_ack_man = 1'b0;
        #1;
        check_eq("t4_m0_vld", 32'(rr_grant_vld), 32'd1);
        check_eq("t4_m0_idx", 32'(rr_grant_idx), 32'd0);
        @(negedge clk);
        m_cyc = '0; m_stb = '0;
        repeat (2) @(negedge clk);

        // Slave never answers m0.
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
`ifdef ARB_TIMEOUT_EN
        first_err = -1; n_err = 0; abort_stb = 1'b1;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clk);
            #1;
            if (rr_m_err[0]) begin
                n_err++;
                if (first_err < 0) begin
                    first_err = c;
                    abort_stb = rr_s_stb;
                end
            end
            if (c == TMO) check_eq("t5_after_abort_vld", 32'(rr_grant_vld), 32'd0);
        end
        check_eq("t5_err_cycle", 32'(first_err), 32'(TMO - 1));
        check_eq("t5_err_count", 32'(n_err),     32'd1);
        check_eq("t5_abort_stb", 32'(abort_stb), 32'd0);
`else
        err_seen = 0;
        repeat (1000) begin
            @(negedge clk);
            #1;
            if (rr_m_err != '0) err_seen++;
        end
        check_eq("t5_no_err",    32'(err_seen),     32'd0);
        check_eq("t5_stall_vld", 32'(rr_grant_vld), 32'd1);
        check_eq("t5_stall_idx", 32'(rr_grant_idx), 32'd0);
`endif
        @(negedge clk);
        m_cyc = '0; m_stb = '0;
        repeat (3) @(negedge clk);

        // Reset asserted in the middle of m2's grant.
        @(negedge clk);
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t6_idx", 32'(rr_grant_idx), 32'd2);
        s_ack_man = 1'b1;
        #1;
        check_eq("t6_pre_ack", 32'(rr_m_ack), 32'b100);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_s_cyc", 32'(rr_s_cyc),     32'd0);
        check_eq("t6_s_stb", 32'(rr_s_stb),     32'd0);
        check_eq("t6_vld",   32'(rr_grant_vld), 32'd0);
        check_eq("t6_m_ack", 32'(rr_m_ack),     32'd0);
        s_ack_man = 1'b0;
        m_cyc = 3'b111; m_stb = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t6_first_vld", 32'(rr_grant_vld), 32'd1);
        check_eq("t6_first_idx", 32'(rr_grant_idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
